fnd_display_arbiter: RTL and testbench

- Shares one 4-digit common-anode 7-segment display (FND) between three requesters: stopwatch, watch, and an alarm/status source.
- Owns digit scanning, hex-to-segment decode and grant scheduling. Switches grants only at frame boundaries, so no digit ever shows mixed data.
- Provides an event overlay that blinks a raw segment pattern for a fixed number of phases and then pulses done. This replaces ad-hoc "finish" blink logic in the mode blocks.

---
 rtl/fnd_display_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_fnd_display_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_display_arbiter.sv
// Shared 4-digit common-anode FND: digit scanning, hex decode, frame-aligned
// priority arbitration between three sources, and a blinking event overlay.
module fnd_display_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 50000000,
  parameter int BLINK_COUNT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [3:0]  dp0,
  input  logic [3:0]  dp1,
  input  logic [3:0]  dp2,
  input  logic        evt_start,
  input  logic [7:0]  evt_pattern,
  output logic [2:0]  grant,
  output logic        evt_busy,
  output logic        evt_done,
  output logic [7:0]  fnd_data,
  output logic [3:0]  fnd_com
);

  localparam int SC_W = $clog2(SCAN_DIV);
  localparam int BK_W = $clog2(BLINK_DIV);
  localparam int PH_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [SC_W-1:0] SCAN_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [BK_W-1:0] BLINK_LAST = BK_W'(BLINK_DIV - 1);
  localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(BLINK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SHOW, EVENT} state_t;

  state_t          state_reg, state_next;
  logic [SC_W-1:0] scan_cnt_reg, scan_cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic [BK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic [PH_W-1:0] phase_reg, phase_next;
  logic [7:0]      pattern_reg, pattern_next;
  logic [2:0]      grant_reg, grant_next;
  logic            evt_done_reg, evt_done_next;
  logic [3:0]      fnd_com_reg, fnd_com_next;
  logic [7:0]      fnd_data_reg, fnd_data_next;

  logic            scan_term;
  logic            frame_end;
  logic [15:0]     data_arr [3];
  logic [3:0]      dp_arr   [3];
  logic [3:0]      nib_arr  [3];
  logic [2:0]      dp_bits;
  logic [3:0]      owner_nib;
  logic            owner_dp;

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  // Active-low g..a segment codes; the dp bit is merged in separately.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign scan_term     = (scan_cnt_reg == SCAN_LAST);
  assign frame_end     = scan_term && (idx_reg == 2'd3);
  assign scan_cnt_next = scan_term ? '0 : scan_cnt_reg + 1'b1;
  assign idx_next      = scan_term ? idx_reg + 2'd1 : idx_reg;
  assign fnd_com_next  = ~(4'b0001 << idx_next);

  assign data_arr[0] = data0;
  assign data_arr[1] = data1;
  assign data_arr[2] = data2;
  assign dp_arr[0]   = dp0;
  assign dp_arr[1]   = dp1;
  assign dp_arr[2]   = dp2;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      assign nib_arr[gi] = data_arr[gi][{idx_next, 2'b00} +: 4];
      assign dp_bits[gi] = dp_arr[gi][idx_next];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    pattern_next   = pattern_reg;
    evt_done_next  = 1'b0;
    // A start pulse overrides both frame arbitration and a finishing event.
    if (evt_start) begin
      state_next     = EVENT;
      grant_next     = 3'b000;
      blink_cnt_next = '0;
      phase_next     = '0;
      pattern_next   = evt_pattern;
    end else begin
      case (state_reg)
        IDLE, SHOW: begin
          if (frame_end) begin
            grant_next = pick(req);
            state_next = (req != 3'b000) ? SHOW : IDLE;
          end
        end
        EVENT: begin
          if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            if (phase_reg == PHASE_LAST) begin
              evt_done_next = 1'b1;
              grant_next    = pick(req);
              state_next    = (req != 3'b000) ? SHOW : IDLE;
            end else begin
              phase_next = phase_reg + 1'b1;
            end
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          grant_next = 3'b000;
        end
      endcase
    end
  end

  // Decode from the next owner so the first slot of a new frame never shows old data.
  always_comb begin
    owner_nib = 4'h0;
    owner_dp  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant_next[i]) begin
        owner_nib = nib_arr[i];
        owner_dp  = dp_bits[i];
      end
    end
  end

  always_comb begin
    fnd_data_next = 8'hFF;
    case (state_next)
      SHOW:    fnd_data_next = {~owner_dp, hex_seg(owner_nib)};
      EVENT:   if (!phase_next[0]) fnd_data_next = pattern_next;
      default: fnd_data_next = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      scan_cnt_reg  <= '0;
      idx_reg       <= 2'd0;
      blink_cnt_reg <= '0;
      phase_reg     <= '0;
      pattern_reg   <= 8'hFF;
      grant_reg     <= 3'b000;
      evt_done_reg  <= 1'b0;
      fnd_com_reg   <= 4'b1111;
      fnd_data_reg  <= 8'hFF;
    end else begin
      state_reg     <= state_next;
      scan_cnt_reg  <= scan_cnt_next;
      idx_reg       <= idx_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      pattern_reg   <= pattern_next;
      grant_reg     <= grant_next;
      evt_done_reg  <= evt_done_next;
      fnd_com_reg   <= fnd_com_next;
      fnd_data_reg  <= fnd_data_next;
    end
  end

  assign grant    = grant_reg;
  assign evt_busy = (state_reg == EVENT);
  assign evt_done = evt_done_reg;
  assign fnd_data = fnd_data_reg;
  assign fnd_com  = fnd_com_reg;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Scoreboard bench for fnd_display_arbiter: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_fnd_display_arbiter;

  localparam int NA = -1;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [3:0]  dp0, dp1, dp2;
  logic        evt_start;
  logic [7:0]  evt_pattern;
  logic [2:0]  grant;
  logic        evt_busy;
  logic        evt_done;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;

  typedef struct {
    int    at;
    int    n;
    string nm;
    int    com;
    int    data;
    int    grant;
    int    busy;
    int    done;
    int    dcnt;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   base     = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  fnd_display_arbiter #(
    .SCAN_DIV   (4),
    .BLINK_DIV  (16),
    .BLINK_COUNT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .dp0        (dp0),
    .dp1        (dp1),
    .dp2        (dp2),
    .evt_start  (evt_start),
    .evt_pattern(evt_pattern),
    .grant      (grant),
    .evt_busy   (evt_busy),
    .evt_done   (evt_done),
    .fnd_data   (fnd_data),
    .fnd_com    (fnd_com)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic expect_at(input int n, input string nm, input int com, input int data,
                           input int gnt, input int busy, input int done, input int dcnt);
    exp_t e;
    e.at = base + n; e.n = n; e.nm = nm;
    e.com = com; e.data = data; e.grant = gnt;
    e.busy = busy; e.done = done; e.dcnt = dcnt;
    sb.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
    if (cyc != base + n) begin
      errors++;
      $display("FAIL goto n=%0d: cycle %0d already past target %0d", n, cyc, base + n);
    end
  endtask

  task automatic cmp(input string nm, input string fld, input int n,
                     input logic [31:0] got, input int want);
    if (want >= 0) begin
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s.%s n=%0d: got %0h want %0h", nm, fld, n, got, want);
      end
    end
  endtask

  // Monitor: counts evt_done pulses and checks every expectation due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (evt_done === 1'b1) done_cnt++;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        if (e.at < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s late: checked at cycle %0d, due %0d", e.nm, cyc, e.at);
        end else begin
          $display("n=%0d %s com=%b data=%h grant=%b busy=%b done=%b dcnt=%0d",
                   e.n, e.nm, fnd_com, fnd_data, grant, evt_busy, evt_done, done_cnt);
          cmp(e.nm, "com",   e.n, {28'd0, fnd_com},  e.com);
          cmp(e.nm, "data",  e.n, {24'd0, fnd_data}, e.data);
          cmp(e.nm, "grant", e.n, {29'd0, grant},    e.grant);
          cmp(e.nm, "busy",  e.n, {31'd0, evt_busy}, e.busy);
          cmp(e.nm, "done",  e.n, {31'd0, evt_done}, e.done);
          cmp(e.nm, "dcnt",  e.n, done_cnt,          e.dcnt);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 3'b000;
    data0 = 16'h0; data1 = 16'h0; data2 = 16'h0;
    dp0 = 4'h0; dp1 = 4'h0; dp2 = 4'h0;
    evt_start = 1'b0; evt_pattern = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    base  = cyc;

    // Reset values, then idle scanning
    expect_at(0,  "rst",       4'b1111, 8'hFF, 0, 0, 0, NA);
    expect_at(1,  "idle_d0",   4'b1110, 8'hFF, 0, NA, NA, NA);
    expect_at(5,  "idle_d1",   4'b1101, 8'hFF, 0, NA, NA, NA);
    expect_at(9,  "idle_d2",   4'b1011, 8'hFF, 0, NA, NA, NA);
    expect_at(13, "idle_d3",   4'b0111, 8'hFF, 0, NA, NA, NA);
    expect_at(17, "idle_wrap", 4'b1110, 8'hFF, 0, NA, NA, NA);

    // Single requester
    goto(17);
    req = 3'b001; data0 = 16'h1234; dp0 = 4'b0100;
    expect_at(31, "req_wait", 4'b0111, 8'hFF, 3'b000, NA, NA, NA);
    expect_at(32, "own0_d0",  4'b1110, 8'h99, 3'b001, NA, NA, NA);
    expect_at(36, "own0_d1",  4'b1101, 8'hB0, 3'b001, NA, NA, NA);
    expect_at(40, "own0_d2",  4'b1011, 8'h24, 3'b001, NA, NA, NA);
    expect_at(44, "own0_d3",  4'b0111, 8'hF9, 3'b001, NA, NA, NA);

    // Preemption by req[2] mid-frame
    goto(49);
    req = 3'b101; data2 = 16'hABCD; dp2 = 4'b0000;
    expect_at(52, "pre_hold", 4'b1101, 8'hB0, 3'b001, NA, NA, NA);
    expect_at(63, "pre_last", 4'b0111, 8'hF9, 3'b001, NA, NA, NA);
    expect_at(64, "own2_d0",  4'b1110, 8'hA1, 3'b100, NA, NA, NA);
    expect_at(68, "own2_d1",  4'b1101, 8'hC6, 3'b100, NA, NA, NA);
    expect_at(72, "own2_d2",  4'b1011, 8'h83, 3'b100, NA, NA, NA);
    expect_at(76, "own2_d3",  4'b0111, 8'h88, 3'b100, NA, NA, NA);

    // Owner release to req[1], then to idle
    goto(77);
    req = 3'b010; data1 = 16'h5678; dp1 = 4'b0001;
    expect_at(79, "rel_hold", 4'b0111, 8'h88, 3'b100, NA, NA, NA);
    expect_at(80, "own1_d0",  4'b1110, 8'h00, 3'b010, NA, NA, NA);
    expect_at(84, "own1_d1",  4'b1101, 8'hF8, 3'b010, NA, NA, NA);
    goto(85);
    req = 3'b000;
    expect_at(95, "rel_last",   4'b0111, 8'h92, 3'b010, NA, NA, NA);
    expect_at(96, "idle_again", 4'b1110, 8'hFF, 3'b000, NA, NA, NA);

    // Event A with owner 1
    goto(97);
    req = 3'b010;
    expect_at(112, "own1_back", 4'b1110, 8'h00, 3'b010, 0, 0, NA);
    goto(114);
    evt_start = 1'b1; evt_pattern = 8'hBF;
    goto(115);
    evt_start = 1'b0;
    expect_at(115, "evtA_enter",  4'b1110, 8'hBF, 0, 1, 0, NA);
    expect_at(130, "evtA_p0_end", NA, 8'hBF, 0, 1, 0, NA);
    expect_at(131, "evtA_p1",     NA, 8'hFF, 0, 1, 0, NA);
    expect_at(146, "evtA_p1_end", NA, 8'hFF, 0, 1, 0, NA);
    expect_at(147, "evtA_p2",     NA, 8'hBF, 0, 1, 0, NA);
    expect_at(162, "evtA_p2_end", NA, 8'hBF, 0, 1, 0, NA);
    expect_at(163, "evtA_p3",     NA, 8'hFF, 0, 1, 0, NA);
    expect_at(178, "evtA_p3_end", NA, 8'hFF, 0, 1, 0, 0);
    expect_at(179, "evtA_done",   4'b1110, 8'h00, 3'b010, 0, 1, 1);
    expect_at(180, "evtA_after",  NA, NA, 3'b010, 0, 0, 1);

    // Event B restarted as C in phase 2
    goto(181);
    evt_start = 1'b1; evt_pattern = 8'hC0;
    goto(182);
    evt_start = 1'b0;
    expect_at(182, "evtB_enter", NA, 8'hC0, 0, 1, 0, NA);
    goto(216);
    evt_start = 1'b1; evt_pattern = 8'h7F;
    expect_at(216, "evtB_p2", NA, 8'hC0, 0, 1, 0, NA);
    goto(217);
    evt_start = 1'b0;
    expect_at(217, "evtC_restart", NA, 8'h7F, 0, 1, 0, NA);
    expect_at(232, "evtC_p0_end",  NA, 8'h7F, 0, 1, 0, NA);
    expect_at(233, "evtC_p1",      NA, 8'hFF, 0, 1, 0, NA);
    expect_at(246, "evtB_no_done", NA, NA, 0, 1, 0, 1);
    expect_at(280, "evtC_p3_end",  NA, 8'hFF, 0, 1, 0, 1);
    expect_at(281, "evtC_done",    4'b1011, 8'h82, 3'b010, 0, 1, 2);

    // Event D restarted as E exactly when D would finish
    goto(282);
    evt_start = 1'b1; evt_pattern = 8'hF9;
    goto(283);
    evt_start = 1'b0;
    expect_at(283, "evtD_enter", NA, 8'hF9, 0, 1, 0, NA);
    goto(346);
    evt_start = 1'b1; evt_pattern = 8'hA4;
    expect_at(346, "evtD_p3", NA, 8'hFF, 0, 1, 0, NA);
    goto(347);
    evt_start = 1'b0;
    expect_at(347, "evtE_collide", NA, 8'hA4, 0, 1, 0, 2);

    // Reset during phase 1 of event E
    goto(365);
    reset = 1'b1;
    expect_at(365, "evtE_p1",  NA, 8'hFF, 0, 1, 0, NA);
    expect_at(366, "rst_mid",  4'b1111, 8'hFF, 0, 0, 0, NA);
    goto(367);
    reset = 1'b0;
    expect_at(367, "rst_hold",   4'b1111, 8'hFF, 0, 0, 0, NA);
    expect_at(368, "rst_rel",    4'b1110, 8'hFF, 0, 0, 0, NA);
    expect_at(382, "rearb_wait", NA, 8'hFF, 0, 0, 0, NA);
    expect_at(383, "rearb",      4'b1110, 8'h00, 3'b010, 0, 0, NA);
    expect_at(411, "evtE_none",  NA, NA, 3'b010, 0, 0, 2);
    goto(413);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
